branch_predictor: RTL and testbench

//  Fetch-side counterpart of the Execute-stage branch resolver. Predicts in F whether PCF is a taken

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch predictor paired with the Execute-stage branch resolver.
// A direct-mapped BTB (valid, tag, target) plus a 2-bit saturating counter
// per entry predicts taken/not-taken and the next fetch PC for PCF. Resolved
// branches in E train the table, and mispredictions are flagged with the
// corrected PC for the F/D flush.
//
// Optional feature: define BP_PERF_CNT_EN to add saturating branch and
// misprediction counters (BranchCountE, MispredCountE).
//
// Ports
//   clk            in   1   clock, posedge
//   reset          in   1   asynchronous, active-high
//   PCF            in   32  fetch PC
//   PredTakenF     out  1   predicted taken
//   PredPCF        out  32  predicted next PC
//   PCE            in   32  PC of the instruction in E
//   BranchE        in   1   E holds a valid conditional branch
//   NeedBranchE    in   1   resolved outcome: taken
//   BranchTargetE  in   32  resolved target
//   PredTakenE     in   1   prediction carried to E
//   PredPCE        in   32  predicted PC carried to E
//   MispredictE    out  1   redirect required
//   CorrectPCE     out  32  redirect PC
//   BranchCountE   out  32  (BP_PERF_CNT_EN) resolved branch count
//   MispredCountE  out  32  (BP_PERF_CNT_EN) misprediction count
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredPCF,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic        NeedBranchE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredPCE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] BranchCountE,
    output logic [31:0] MispredCountE
`endif
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                  valid      [ENTRIES];
    logic [1:0]            ctr        [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
    logic [31:0]           target_mem [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_f;
    logic                  hit_e;
    logic [31:0]           pcf_plus4;
    logic [31:0]           pce_plus4;

    assign idx_f = PCF[INDEX_BITS+1:2];
    assign tag_f = PCF[INDEX_BITS+2 +: TAG_BITS];
    assign idx_e = PCE[INDEX_BITS+1:2];
    assign tag_e = PCE[INDEX_BITS+2 +: TAG_BITS];

    assign pcf_plus4 = PCF + 32'd4;
    assign pce_plus4 = PCE + 32'd4;

    // Prediction reads the table directly; an E-stage write to the same
    // index becomes visible to F only on the following cycle.
    assign hit_f      = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    assign PredTakenF = hit_f && ctr[idx_f][1];
    assign PredPCF    = PredTakenF ? target_mem[idx_f] : pcf_plus4;

    assign hit_e = valid[idx_e] && (tag_mem[idx_e] == tag_e);

    // A correctly predicted taken branch can still redirect if the BTB
    // supplied a stale target.
    assign MispredictE = BranchE &&
                         ((NeedBranchE != PredTakenE) ||
                          (NeedBranchE && (PredPCE != BranchTargetE)));
    assign CorrectPCE  = NeedBranchE ? BranchTargetE : pce_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
        end else if (BranchE) begin
            if (hit_e) begin
                if (NeedBranchE) begin
                    if (ctr[idx_e] != 2'b11) ctr[idx_e] <= ctr[idx_e] + 2'd1;
                end else begin
                    if (ctr[idx_e] != 2'b00) ctr[idx_e] <= ctr[idx_e] - 2'd1;
                end
            end else if (NeedBranchE) begin
                valid[idx_e] <= 1'b1;
                ctr[idx_e]   <= 2'b10;
            end
        end
    end

    // Tag and target carry no reset. Any taken branch writes them: on a hit
    // the tag is unchanged, on a miss this is the allocation. A write while
    // reset is held is harmless because the entry stays invalid.
    always_ff @(posedge clk) begin
        if (BranchE && NeedBranchE) begin
            tag_mem[idx_e]    <= tag_e;
            target_mem[idx_e] <= BranchTargetE;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BranchCountE  <= 32'd0;
            MispredCountE <= 32'd0;
        end else begin
            if (BranchE && (BranchCountE != 32'hFFFF_FFFF))
                BranchCountE <= BranchCountE + 32'd1;
            if (MispredictE && (MispredCountE != 32'hFFFF_FFFF))
                MispredCountE <= MispredCountE + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int IB = 6;
    localparam int TB = 8;
    localparam int NE = 1 << IB;
    localparam logic [31:0] PC_A     = 32'h0000_0100;
    localparam logic [31:0] PC_ALIAS = 32'h0000_0100 + (32'd1 << (IB + 2));

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PredPCF, PCE, BranchTargetE, PredPCE, CorrectPCE;
    logic        PredTakenF, BranchE, NeedBranchE, PredTakenE, MispredictE;
`ifdef BP_PERF_CNT_EN
    logic [31:0] BranchCountE, MispredCountE;
    logic [31:0] m_bcnt, m_mcnt;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
        .PCE(PCE), .BranchE(BranchE), .NeedBranchE(NeedBranchE), .BranchTargetE(BranchTargetE),
        .PredTakenE(PredTakenE), .PredPCE(PredPCE), .MispredictE(MispredictE), .CorrectPCE(CorrectPCE)
`ifdef BP_PERF_CNT_EN
        , .BranchCountE(BranchCountE), .MispredCountE(MispredCountE)
`endif
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // reference model of the table
    logic        m_valid [NE];
    logic [7:0]  m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    logic [1:0]  m_ctr   [NE];

    // last driven E-side transaction, applied to the model at the clock edge
    logic        l_br, l_need, l_mis;
    logic [31:0] l_pce, l_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: obs = {31'd0, PredTakenF};
                1: obs = PredPCF;
                2: obs = {31'd0, MispredictE};
                3: obs = CorrectPCE;
`ifdef BP_PERF_CNT_EN
                4: obs = BranchCountE;
                5: obs = MispredCountE;
`endif
                default: obs = 'x;
            endcase
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'(pc[IB+1:2]);
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        int i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == pc[IB+2 +: TB]) && m_ctr[i][1];
    endfunction

    function automatic logic [31:0] m_pc(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2'b01;
        end
`ifdef BP_PERF_CNT_EN
        m_bcnt = 0;
        m_mcnt = 0;
`endif
    endtask

    task automatic m_update();
        int   i;
        logic hit;
        i   = m_idx(l_pce);
        hit = m_valid[i] && (m_tag[i] == l_pce[IB+2 +: TB]);
        if (hit) begin
            if (l_need) begin
                if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
                m_tgt[i] = l_tgt;
            end else if (m_ctr[i] != 2'b00) begin
                m_ctr[i] = m_ctr[i] - 2'd1;
            end
        end else if (l_need) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = l_pce[IB+2 +: TB];
            m_tgt[i]   = l_tgt;
            m_ctr[i]   = 2'b10;
        end
`ifdef BP_PERF_CNT_EN
        m_bcnt = m_bcnt + 1;
        if (l_mis) m_mcnt = m_mcnt + 1;
`endif
    endtask

    // Drive one cycle of inputs and queue the expected outputs.
    task automatic drive(input logic [31:0] pcf, input logic br, input logic [31:0] pce,
                         input logic need, input logic [31:0] tgt, input logic pte,
                         input logic [31:0] ppe);
        PCF = pcf; BranchE = br; PCE = pce; NeedBranchE = need;
        BranchTargetE = tgt; PredTakenE = pte; PredPCE = ppe;
        l_br = br; l_pce = pce; l_need = need; l_tgt = tgt;
        l_mis = br && ((need != pte) || (need && (ppe != tgt)));
        expect_val("pred_taken", 0, {31'd0, m_taken(pcf)});
        expect_val("pred_pc", 1, m_pc(pcf));
        expect_val("mispredict", 2, {31'd0, l_mis});
        expect_val("correct_pc", 3, need ? tgt : pce + 32'd4);
`ifdef BP_PERF_CNT_EN
        expect_val("branch_cnt", 4, m_bcnt);
        expect_val("mispred_cnt", 5, m_mcnt);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        if (l_br && !reset) m_update();
        #1;
    endtask

    // Resolve a branch at pc whose prediction came from the current table.
    task automatic res(input logic [31:0] pc, input logic need, input logic [31:0] tgt);
        drive(pc, 1'b1, pc, need, tgt, m_taken(pc), m_pc(pc));
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    logic [31:0] pool [6];
    logic [31:0] tpool [4];

    initial begin
        reset = 1'b1;
        PCF = 0; PCE = 0; BranchE = 0; NeedBranchE = 0;
        BranchTargetE = 0; PredTakenE = 0; PredPCE = 0;
        l_br = 0; l_pce = 0; l_need = 0; l_tgt = 0; l_mis = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // post-reset prediction and a not-taken branch that predicted not-taken
        drive(PC_A, 1'b1, PC_A, 1'b0, 32'h0, 1'b0, PC_A + 32'd4);
        expect_val("rst_pred_taken", 0, 32'd0);
        expect_val("rst_pred_pc", 1, 32'h104);
        expect_val("rst_nt_mispred", 2, 32'd0);
        tick();

        // cold taken: redirect, allocation; F sees old contents in the same cycle
        drive(PC_A, 1'b1, PC_A, 1'b1, 32'h80, 1'b0, PC_A + 32'd4);
        expect_val("cold_mispred", 2, 32'd1);
        expect_val("cold_correct_pc", 3, 32'h80);
        expect_val("cold_same_cycle_pred", 0, 32'd0);
        tick();
        look(PC_A);
        expect_val("alloc_pred_taken", 0, 32'd1);
        expect_val("alloc_pred_pc", 1, 32'h80);
        tick();

        // hysteresis and saturation at both bounds
        res(PC_A, 1'b0, 32'h80); tick();
        look(PC_A); expect_val("hyst_01", 0, 32'd0); tick();
        res(PC_A, 1'b1, 32'h80); tick();
        res(PC_A, 1'b1, 32'h80); tick();
        look(PC_A); expect_val("hyst_11", 0, 32'd1); tick();
        res(PC_A, 1'b1, 32'h80); tick();
        res(PC_A, 1'b0, 32'h80); tick();
        look(PC_A); expect_val("sat_hi_10", 0, 32'd1); tick();
        res(PC_A, 1'b0, 32'h80); tick();
        look(PC_A); expect_val("sat_hi_01", 0, 32'd0); tick();
        res(PC_A, 1'b0, 32'h80); tick();
        res(PC_A, 1'b0, 32'h80); tick();
        res(PC_A, 1'b1, 32'h80); tick();
        look(PC_A); expect_val("sat_lo_01", 0, 32'd0); tick();
        res(PC_A, 1'b1, 32'h80); tick();
        look(PC_A); expect_val("sat_lo_10", 0, 32'd1); tick();

        // target change on a confident hit
        res(PC_A, 1'b1, 32'h80); tick();
        drive(PC_A, 1'b1, PC_A, 1'b1, 32'hC0, 1'b1, 32'h80);
        expect_val("tgt_mispred", 2, 32'd1);
        expect_val("tgt_correct_pc", 3, 32'hC0);
        tick();
        look(PC_A); expect_val("tgt_new_pred", 1, 32'hC0); tick();

        // aliasing: taken replaces, not-taken miss leaves resident entry
        res(PC_ALIAS, 1'b1, 32'h300); tick();
        look(PC_A);
        expect_val("alias_evict_taken", 0, 32'd0);
        expect_val("alias_evict_pc", 1, 32'h104);
        tick();
        res(PC_A, 1'b0, 32'h0); tick();
        look(PC_ALIAS); expect_val("alias_resident", 1, 32'h300); tick();

        // non-branch in E never updates, even with a taken-looking outcome
        drive(PC_ALIAS, 1'b0, PC_A, 1'b1, 32'h999, 1'b0, 32'h0);
        expect_val("nobranch_mispred", 2, 32'd0);
        tick();
        look(PC_A); expect_val("nobranch_no_alloc", 0, 32'd0); tick();

        // PCF+4 wraps at the top of the address space
        look(32'hFFFF_FFFC); expect_val("wrap_pc", 1, 32'h0); tick();

        // async reset between edges with a valid entry
        drive(PC_ALIAS, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        sb.delete();
        #2 reset = 1'b1;
        #1;
        m_reset();
        expect_val("async_rst_taken", 0, 32'd0);
        expect_val("async_rst_pc", 1, PC_ALIAS + 32'd4);
`ifdef BP_PERF_CNT_EN
        expect_val("async_rst_bcnt", 4, 32'd0);
        expect_val("async_rst_mcnt", 5, 32'd0);
`endif
        drain();

        // update attempted while reset held: entry stays invalid
        res(PC_ALIAS, 1'b1, 32'h300); tick();
        reset = 1'b0;
        look(PC_ALIAS); expect_val("rst_wins_update", 0, 32'd0); tick();

        // randomized traffic with occasional corrupted E-side predictions
        pool[0] = 32'h0000_0100; pool[1] = PC_ALIAS; pool[2] = 32'h0000_0104;
        pool[3] = 32'h0000_1104; pool[4] = 32'h0000_03FC; pool[5] = 32'hFFFF_FFFC;
        tpool[0] = 32'h80; tpool[1] = 32'hC0; tpool[2] = 32'h300; tpool[3] = 32'h4000;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pce, pcf, tgt, ppe;
            logic        pte, br, need;
            pce  = pool[$urandom_range(0, 5)];
            pcf  = ($urandom_range(0, 1) == 0) ? pce : pool[$urandom_range(0, 5)];
            tgt  = tpool[$urandom_range(0, 3)];
            br   = ($urandom_range(0, 3) != 0);
            need = $urandom_range(0, 1) == 1;
            pte  = m_taken(pce);
            ppe  = m_pc(pce);
            if ($urandom_range(0, 9) == 0) pte = ~pte;
            if ($urandom_range(0, 9) == 0) ppe = tpool[$urandom_range(0, 3)];
            drive(pcf, br, pce, need, tgt, pte, ppe);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
